mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory-access stage of the multicycle RV32I pipeline. Sits between execute and write-back.
- Accepts one instruction at a time from execute and, for loads and stores, performs a request/ack transaction on the data-memory port.
- Aligns and sign/zero-extends load data, then hands the result to write-back through the wb_* interface.
- Drives a bypass (bp_*) pair for the register it is carrying.

Parameters:
- XLEN, 32, data/address width.
- REG_IDX, 5, register index width.
- STRB_W, 4, byte-strobe width (XLEN/8).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- startSig  in  1  pipeline start pulse.
- beforePipReadyToSend  in  1  execute has a valid entry.
- nextPipReadyToRcv  in  1  write-back can accept.
- ex_valid  in  1  entry writes a register.
- ex_rd_idx  in  REG_IDX  destination register.
- ex_result  in  XLEN  ALU result: address for load/store, value otherwise.
- ex_store_data  in  XLEN  rs2 value for stores.
- ex_mem_op  in  2  00 none, 01 load, 10 store, 11 treated as none.
- ex_funct3  in  3  access size/sign.
- curPipReadyToRcv  out  1  stage accepts this cycle.
- curPipReadyToSend  out  1  result presented to write-back.
- dmem_req  out  1  memory request.
- dmem_we  out  1  request is a store.
- dmem_addr  out  XLEN  word-aligned address (low 2 bits zero).
- dmem_wdata  out  XLEN  replicated store data.
- dmem_wstrb  out  STRB_W  byte enables.
- dmem_rdata  in  XLEN  load word.
- dmem_ack  in  1  transaction complete.
- wb_valid  out  1  to write-back.
- wb_idx  out  REG_IDX  to write-back.
- wb_val  out  XLEN  to write-back.
- wb_en_meta  out  1  write-back latch enable for valid/idx.
- wb_en_data  out  1  write-back latch enable for value.
- bp_idx  out  REG_IDX  bypass index, 0 when none.
- bp_val  out  XLEN  bypass value, 0 when none.
- misalign_err  out  1  carried entry was misaligned or illegal.

Behaviour:
- States: IDLE, WAIT_BEF, MEM_WAIT, SENDING, WAIT_SEND.
- Reset: state IDLE, all internal registers 0. Every output is 0 in IDLE.
- Accept condition: accept = beforePipReadyToSend and (startSig or WAIT_BEF or (SENDING/WAIT_SEND and nextPipReadyToRcv)).
  - On accept, latch valid, rd, result, store data, op and funct3.
- curPipReadyToRcv = WAIT_BEF | (curPipReadyToSend & nextPipReadyToRcv).
- curPipReadyToSend = SENDING | WAIT_SEND.
- Transitions:
  - rst wins over all other inputs.
  - startSig: accept if beforePipReadyToSend, else go to WAIT_BEF.
  - On accept, the next state is MEM_WAIT for an aligned legal load/store, otherwise SENDING.
  - MEM_WAIT: stay until dmem_ack, then go to SENDING.
  - SENDING/WAIT_SEND:
    - If nextPipReadyToRcv: accept a new entry, or go to WAIT_BEF if none is available.
    - Otherwise go to WAIT_SEND.
  - IDLE stays IDLE without startSig.
- Memory port:
  - dmem_req is high exactly while in MEM_WAIT. First request cycle is 1 cycle after accept.
  - addr/we/wdata/wstrb are stable for the whole request.
  - dmem_ack outside MEM_WAIT is ignored. ack in the first MEM_WAIT cycle is legal, giving minimum load latency of 2 cycles from accept to SENDING.
  - On ack for a load, capture the extended rdata into the value register.
- Access rules, with addr[1:0] = a:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
    - Byte select is rdata >> 8a. Half select is rdata >> 8a with a in {0,2}.
    - LB/LH sign-extend, LBU/LHU zero-extend.
  - Stores: 000 SB, 001 SH, 010 SW.
    - SB: wstrb = 0001<<a, byte replicated x4.
    - SH: wstrb = 0011<<a, half replicated x2.
    - SW: wstrb = 1111.
  - Misaligned (LH/LHU/SH with a[0]=1; LW/SW with a!=0) or illegal funct3: no memory request, go straight to SENDING with wb_valid=0 and misalign_err=1 while presented.
- Outputs while presenting:
  - Stores: wb_valid=0.
  - Non-memory ops: wb_val = latched result.
  - wb_en_meta = wb_en_data = curPipReadyToSend & nextPipReadyToRcv.
  - bp_idx/bp_val are non-zero only in SENDING/WAIT_SEND with wb_valid=1 and idx!=0.
- Reset mid-MEM_WAIT: go to IDLE, dmem_req low the next cycle, any late ack ignored.
- An entry with ex_valid=0 and a load/store op still performs the memory access; wb_valid stays 0.

Decomposition:
- Shared package:
  - mem_op encodings (MEM_NONE/LOAD/STORE)
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state encodings
  - XLEN/REG_IDX defaults
- One combinational sub-module, load_store_align:
  - Inputs: op, funct3, addr[1:0], store data, rdata.
  - Outputs: wstrb, wdata, extended load value, misalign flag.

Test Plan:
- ALU op, rd=5, result 0x1234, next ready -> SENDING 1 cycle after accept, wb_en_*=1, wb_val=0x1234, bp_idx=5, dmem_req never high.
- LB at addr 0x103, rdata 0x80FF_00AA, ack after 3 cycles -> dmem_addr 0x100, req high 3 cycles, wb_val 0xFFFF_FF80. LBU of the same access -> 0x0000_0080.
- SH at 0x202, data 0xABCD_1234 -> wstrb 1100, wdata 0x1234_1234, we=1, wb_valid=0, bp_idx=0.
- LW at 0x105 -> no dmem_req, misalign_err=1, wb_valid=0, SENDING next cycle.
- Result held with nextPipReadyToRcv=0 for 4 cycles -> WAIT_SEND, wb_en_*=0, curPipReadyToRcv=0. On release with upstream ready -> back-to-back accept in the same cycle.
- rst asserted during MEM_WAIT followed by a late ack -> IDLE, outputs 0, ack ignored, next startSig operates normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-access stage: op codes, funct3 sizes,
// FSM states and the access-legality rule used by both the stage and its aligner.
package mem_access_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int REG_IDX_DEF = 5;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10
  } mem_op_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BEF  = 3'd1,
    MEM_WAIT  = 3'd2,
    SENDING   = 3'd3,
    WAIT_SEND = 3'd4
  } state_e;

  // True when a load/store must not reach memory: misaligned or unknown size.
  function automatic logic access_fault(input logic [1:0] op, input logic [2:0] f3,
                                        input logic [1:0] a);
    logic fault;
    fault = 1'b0;
    if (op == MEM_LOAD) begin
      case (f3)
        F3_B, F3_BU: fault = 1'b0;
        F3_H, F3_HU: fault = a[0];
        F3_W:        fault = |a;
        default:     fault = 1'b1;
      endcase
    end else if (op == MEM_STORE) begin
      case (f3)
        F3_B:    fault = 1'b0;
        F3_H:    fault = a[0];
        F3_W:    fault = |a;
        default: fault = 1'b1;
      endcase
    end
    return fault;
  endfunction

endpackage

// File: rtl/mem_access_load_store_align.sv
// Byte-lane steering for stores and lane selection plus sign/zero extension for loads.
module load_store_align
  import mem_access_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int STRB_W = XLEN / 8
) (
  input  logic [1:0]        op_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [STRB_W-1:0] wstrb_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN-1:0]   load_val_o,
  output logic              misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    wstrb_o    = '0;
    wdata_o    = '0;
    load_val_o = '0;
    misalign_o = access_fault(op_i, funct3_i, addr_lo_i);

    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    case (funct3_i)
      F3_B:    load_val_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_H:    load_val_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_W:    load_val_o = rdata_i;
      F3_BU:   load_val_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_HU:   load_val_o = {{(XLEN-16){1'b0}}, half_sel};
      default: load_val_o = '0;
    endcase

    if (op_i == MEM_STORE && !misalign_o) begin
      case (funct3_i)
        F3_B: begin
          wstrb_o = STRB_W'(1) << addr_lo_i;
          wdata_o = {STRB_W{store_data_i[7:0]}};
        end
        F3_H: begin
          wstrb_o = STRB_W'(3) << addr_lo_i;
          wdata_o = {(STRB_W/2){store_data_i[15:0]}};
        end
        default: begin
          wstrb_o = '1;
          wdata_o = store_data_i;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage of the multicycle RV32I pipeline: holds one entry from
// execute, runs its data-memory transaction, and presents the result to write-back.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int REG_IDX = REG_IDX_DEF,
  parameter int STRB_W  = XLEN / 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               startSig,
  input  logic               beforePipReadyToSend,
  input  logic               nextPipReadyToRcv,
  input  logic               ex_valid,
  input  logic [REG_IDX-1:0] ex_rd_idx,
  input  logic [XLEN-1:0]    ex_result,
  input  logic [XLEN-1:0]    ex_store_data,
  input  logic [1:0]         ex_mem_op,
  input  logic [2:0]         ex_funct3,
  output logic               curPipReadyToRcv,
  output logic               curPipReadyToSend,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [XLEN-1:0]    dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  output logic [STRB_W-1:0]  dmem_wstrb,
  input  logic [XLEN-1:0]    dmem_rdata,
  input  logic               dmem_ack,
  output logic               wb_valid,
  output logic [REG_IDX-1:0] wb_idx,
  output logic [XLEN-1:0]    wb_val,
  output logic               wb_en_meta,
  output logic               wb_en_data,
  output logic [REG_IDX-1:0] bp_idx,
  output logic [XLEN-1:0]    bp_val,
  output logic               misalign_err
);

  state_e               state_q, state_d;
  logic                 valid_q, valid_d;
  logic [REG_IDX-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]      result_q, result_d;
  logic [XLEN-1:0]      sdata_q, sdata_d;
  logic [1:0]           op_q, op_d;
  logic [2:0]           f3_q, f3_d;
  logic [XLEN-1:0]      val_q, val_d;

  logic [STRB_W-1:0]    al_wstrb;
  logic [XLEN-1:0]      al_wdata;
  logic [XLEN-1:0]      al_load;
  logic                 al_fault;

  logic                 presenting;
  logic                 in_mem;
  logic                 accept;
  logic                 ex_goes_mem;
  state_e               accept_state;

  load_store_align #(.XLEN(XLEN), .STRB_W(STRB_W)) u_align (
    .op_i        (op_q),
    .funct3_i    (f3_q),
    .addr_lo_i   (result_q[1:0]),
    .store_data_i(sdata_q),
    .rdata_i     (dmem_rdata),
    .wstrb_o     (al_wstrb),
    .wdata_o     (al_wdata),
    .load_val_o  (al_load),
    .misalign_o  (al_fault)
  );

  assign presenting = (state_q == SENDING) || (state_q == WAIT_SEND);
  assign in_mem     = (state_q == MEM_WAIT);

  // startSig only launches the pipeline from IDLE; elsewhere it must not
  // overwrite an entry that is in flight or still being presented.
  assign accept = beforePipReadyToSend &&
                  ((startSig && state_q == IDLE) || state_q == WAIT_BEF ||
                   (presenting && nextPipReadyToRcv));

  assign ex_goes_mem  = (ex_mem_op == MEM_LOAD || ex_mem_op == MEM_STORE) &&
                        !access_fault(ex_mem_op, ex_funct3, ex_result[1:0]);
  assign accept_state = ex_goes_mem ? MEM_WAIT : SENDING;

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    rd_d     = rd_q;
    result_d = result_q;
    sdata_d  = sdata_q;
    op_d     = op_q;
    f3_d     = f3_q;
    val_d    = val_q;

    case (state_q)
      IDLE:      if (startSig) state_d = accept ? accept_state : WAIT_BEF;
      WAIT_BEF:  if (accept) state_d = accept_state;
      MEM_WAIT: begin
        if (dmem_ack) begin
          state_d = SENDING;
          if (op_q == MEM_LOAD) val_d = al_load;
        end
      end
      SENDING, WAIT_SEND: begin
        if (nextPipReadyToRcv) state_d = accept ? accept_state : WAIT_BEF;
        else                   state_d = WAIT_SEND;
      end
      default:   state_d = IDLE;
    endcase

    if (accept) begin
      valid_d  = ex_valid;
      rd_d     = ex_rd_idx;
      result_d = ex_result;
      sdata_d  = ex_store_data;
      op_d     = ex_mem_op;
      f3_d     = ex_funct3;
      val_d    = '0;
    end
  end

  // NOTE: state is written with <= only, and the synchronous reset clears every
  // register so no stale entry survives a mid-transaction reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      sdata_q  <= '0;
      op_q     <= '0;
      f3_q     <= '0;
      val_q    <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      sdata_q  <= sdata_d;
      op_q     <= op_d;
      f3_q     <= f3_d;
      val_q    <= val_d;
    end
  end

  assign curPipReadyToSend = presenting;
  assign curPipReadyToRcv  = (state_q == WAIT_BEF) || (presenting && nextPipReadyToRcv);

  assign dmem_req   = in_mem;
  assign dmem_we    = in_mem && (op_q == MEM_STORE);
  assign dmem_addr  = in_mem ? {result_q[XLEN-1:2], 2'b00} : '0;
  assign dmem_wdata = in_mem ? al_wdata : '0;
  assign dmem_wstrb = in_mem ? al_wstrb : '0;

  assign wb_valid     = presenting && valid_q && (op_q != MEM_STORE) && !al_fault;
  assign wb_idx       = presenting ? rd_q : '0;
  assign wb_val       = presenting ? ((op_q == MEM_LOAD) ? val_q : result_q) : '0;
  assign wb_en_meta   = presenting && nextPipReadyToRcv;
  assign wb_en_data   = presenting && nextPipReadyToRcv;
  assign misalign_err = presenting && al_fault;

  assign bp_idx = (wb_valid && rd_q != '0) ? rd_q : '0;
  assign bp_val = (wb_valid && rd_q != '0) ? wb_val : '0;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU pass-through, loads, stores, misalignment,
// back-pressure and reset during a memory transaction.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk;
  logic        rst;
  logic        startSig;
  logic        beforePipReadyToSend;
  logic        nextPipReadyToRcv;
  logic        ex_valid;
  logic [4:0]  ex_rd_idx;
  logic [31:0] ex_result;
  logic [31:0] ex_store_data;
  logic [1:0]  ex_mem_op;
  logic [2:0]  ex_funct3;
  logic        curPipReadyToRcv;
  logic        curPipReadyToSend;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic [4:0]  wb_idx;
  logic [31:0] wb_val;
  logic        wb_en_meta;
  logic        wb_en_data;
  logic [4:0]  bp_idx;
  logic [31:0] bp_val;
  logic        misalign_err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access dut (
    .clk                 (clk),
    .rst                 (rst),
    .startSig            (startSig),
    .beforePipReadyToSend(beforePipReadyToSend),
    .nextPipReadyToRcv   (nextPipReadyToRcv),
    .ex_valid            (ex_valid),
    .ex_rd_idx           (ex_rd_idx),
    .ex_result           (ex_result),
    .ex_store_data       (ex_store_data),
    .ex_mem_op           (ex_mem_op),
    .ex_funct3           (ex_funct3),
    .curPipReadyToRcv    (curPipReadyToRcv),
    .curPipReadyToSend   (curPipReadyToSend),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wdata          (dmem_wdata),
    .dmem_wstrb          (dmem_wstrb),
    .dmem_rdata          (dmem_rdata),
    .dmem_ack            (dmem_ack),
    .wb_valid            (wb_valid),
    .wb_idx              (wb_idx),
    .wb_val              (wb_val),
    .wb_en_meta          (wb_en_meta),
    .wb_en_data          (wb_en_data),
    .bp_idx              (bp_idx),
    .bp_val              (bp_val),
    .misalign_err        (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Skip one edge, present an entry for exactly one accepting edge, then withdraw it.
  task automatic issue(input logic v, input logic [4:0] rd, input logic [31:0] res,
                       input logic [31:0] sd, input logic [1:0] op, input logic [2:0] f3);
    @(posedge clk); #1;
    beforePipReadyToSend = 1'b1;
    ex_valid      = v;
    ex_rd_idx     = rd;
    ex_result     = res;
    ex_store_data = sd;
    ex_mem_op     = op;
    ex_funct3     = f3;
    @(posedge clk); #1;
    beforePipReadyToSend = 1'b0;
  endtask

  initial begin
    rst = 1'b1; startSig = 1'b0; beforePipReadyToSend = 1'b0; nextPipReadyToRcv = 1'b0;
    ex_valid = 1'b0; ex_rd_idx = '0; ex_result = '0; ex_store_data = '0;
    ex_mem_op = MEM_NONE; ex_funct3 = '0; dmem_rdata = 32'h80FF_00AA; dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_send", 32'(curPipReadyToSend), 32'd0);
    check("rst_rcv",  32'(curPipReadyToRcv),  32'd0);
    check("rst_req",  32'(dmem_req),          32'd0);
    check("rst_wbv",  32'(wb_valid),          32'd0);

    // startSig without upstream data parks the stage in WAIT_BEF.
    @(posedge clk); #1 startSig = 1'b1;
    @(posedge clk); #1 startSig = 1'b0;
    @(negedge clk);
    check("waitbef_rcv",  32'(curPipReadyToRcv),  32'd1);
    check("waitbef_send", 32'(curPipReadyToSend), 32'd0);

    // ALU op
    nextPipReadyToRcv = 1'b1;
    issue(1'b1, 5'd5, 32'h1234, 32'h0, MEM_NONE, 3'b000);
    @(negedge clk);
    check("alu_send",   32'(curPipReadyToSend), 32'd1);
    check("alu_en_m",   32'(wb_en_meta),        32'd1);
    check("alu_en_d",   32'(wb_en_data),        32'd1);
    check("alu_wbval",  wb_val,                 32'h1234);
    check("alu_wbidx",  32'(wb_idx),            32'd5);
    check("alu_bpidx",  32'(bp_idx),            32'd5);
    check("alu_bpval",  bp_val,                 32'h1234);
    check("alu_req",    32'(dmem_req),          32'd0);

    // LB at 0x103, ack in the third request cycle
    issue(1'b1, 5'd7, 32'h103, 32'h0, MEM_LOAD, F3_B);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lb_req",  32'(dmem_req), 32'd1);
      check("lb_addr", dmem_addr,      32'h100);
      check("lb_we",   32'(dmem_we),   32'd0);
      if (i == 2) dmem_ack = 1'b1;
    end
    @(posedge clk); #1 dmem_ack = 1'b0;
    @(negedge clk);
    check("lb_req_off", 32'(dmem_req),          32'd0);
    check("lb_send",    32'(curPipReadyToSend), 32'd1);
    check("lb_wbval",   wb_val,                 32'hFFFF_FF80);
    check("lb_wbvalid", 32'(wb_valid),          32'd1);

    // LBU of the same access, ack in the first request cycle
    issue(1'b1, 5'd7, 32'h103, 32'h0, MEM_LOAD, F3_BU);
    @(negedge clk);
    check("lbu_req", 32'(dmem_req), 32'd1);
    dmem_ack = 1'b1;
    @(posedge clk); #1 dmem_ack = 1'b0;
    @(negedge clk);
    check("lbu_send",  32'(curPipReadyToSend), 32'd1);
    check("lbu_wbval", wb_val,                 32'h0000_0080);

    // SH at 0x202
    issue(1'b1, 5'd9, 32'h202, 32'hABCD_1234, MEM_STORE, F3_H);
    @(negedge clk);
    check("sh_req",   32'(dmem_req),   32'd1);
    check("sh_we",    32'(dmem_we),    32'd1);
    check("sh_addr",  dmem_addr,       32'h200);
    check("sh_wstrb", 32'(dmem_wstrb), 32'hC);
    check("sh_wdata", dmem_wdata,      32'h1234_1234);
    dmem_ack = 1'b1;
    @(posedge clk); #1 dmem_ack = 1'b0;
    @(negedge clk);
    check("sh_send",   32'(curPipReadyToSend), 32'd1);
    check("sh_wbv",    32'(wb_valid),          32'd0);
    check("sh_bpidx",  32'(bp_idx),            32'd0);

    // LW at 0x105: misaligned, no memory request
    issue(1'b1, 5'd8, 32'h105, 32'h0, MEM_LOAD, F3_W);
    @(negedge clk);
    check("lwm_req",  32'(dmem_req),          32'd0);
    check("lwm_send", 32'(curPipReadyToSend), 32'd1);
    check("lwm_err",  32'(misalign_err),      32'd1);
    check("lwm_wbv",  32'(wb_valid),          32'd0);

    // Back-pressure for 4 cycles, then back-to-back accept on release
    issue(1'b1, 5'd3, 32'h55, 32'h0, MEM_NONE, 3'b000);
    nextPipReadyToRcv = 1'b0;
    @(negedge clk);
    check("hold_en0", 32'(wb_en_meta), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_send", 32'(curPipReadyToSend), 32'd1);
      check("hold_en_m", 32'(wb_en_meta),        32'd0);
      check("hold_en_d", 32'(wb_en_data),        32'd0);
      check("hold_rcv",  32'(curPipReadyToRcv),  32'd0);
      check("hold_val",  wb_val,                 32'h55);
    end
    nextPipReadyToRcv    = 1'b1;
    beforePipReadyToSend = 1'b1;
    ex_valid = 1'b1; ex_rd_idx = 5'd4; ex_result = 32'h66; ex_mem_op = MEM_NONE;
    #1;
    check("rel_rcv",  32'(curPipReadyToRcv), 32'd1);
    check("rel_en_m", 32'(wb_en_meta),       32'd1);
    @(posedge clk); #1 beforePipReadyToSend = 1'b0;
    @(negedge clk);
    check("b2b_send",  32'(curPipReadyToSend), 32'd1);
    check("b2b_wbval", wb_val,                 32'h66);
    check("b2b_bpidx", 32'(bp_idx),            32'd4);

    // Load with ex_valid=0 still accesses memory but writes nothing
    issue(1'b0, 5'd6, 32'h400, 32'h0, MEM_LOAD, F3_W);
    @(negedge clk);
    check("nv_req",  32'(dmem_req), 32'd1);
    check("nv_addr", dmem_addr,      32'h400);
    dmem_ack = 1'b1;
    @(posedge clk); #1 dmem_ack = 1'b0;
    @(negedge clk);
    check("nv_send",  32'(curPipReadyToSend), 32'd1);
    check("nv_wbv",   32'(wb_valid),          32'd0);
    check("nv_bpidx", 32'(bp_idx),            32'd0);

    // Reset during MEM_WAIT, then a late ack
    issue(1'b1, 5'd10, 32'h300, 32'h0, MEM_LOAD, F3_W);
    @(negedge clk);
    check("rmw_req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_ack = 1'b1;
    @(negedge clk);
    check("rmw_req0",  32'(dmem_req),          32'd0);
    check("rmw_send0", 32'(curPipReadyToSend), 32'd0);
    check("rmw_addr0", dmem_addr,              32'h0);
    @(posedge clk); #1 dmem_ack = 1'b0;
    @(negedge clk);
    check("rmw_send1", 32'(curPipReadyToSend), 32'd0);
    check("rmw_rcv1",  32'(curPipReadyToRcv),  32'd0);
    check("rmw_wbval", wb_val,                 32'h0);

    // Restart with startSig and data already available
    startSig = 1'b1; beforePipReadyToSend = 1'b1;
    ex_valid = 1'b1; ex_rd_idx = 5'd2; ex_result = 32'h77; ex_mem_op = MEM_NONE;
    @(posedge clk); #1;
    startSig = 1'b0; beforePipReadyToSend = 1'b0;
    @(negedge clk);
    check("restart_send",  32'(curPipReadyToSend), 32'd1);
    check("restart_wbval", wb_val,                 32'h77);
    check("restart_bpidx", 32'(bp_idx),            32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
